// File: rtl/memshare_l1pa_regfile.sv
// memshare_l1pa_regfile: L1PA_SPR page store feeding the memShare RFMU.
// Optional per-page even parity: define MEMSHARE_REGFILE_PARITY_EN.
module memshare_l1pa_regfile #(
  parameter int RQST_BITWIDTH       = 5,
  parameter int REGFILE_PAGE_NUM    = 43,
  // must reach every page, so never narrower than clog2 of the page count
  parameter int REGFILE_ADDR_WIDTH  =
    (RQST_BITWIDTH > $clog2(REGFILE_PAGE_NUM)) ?
      RQST_BITWIDTH : $clog2(REGFILE_PAGE_NUM),
  parameter int L1PA_SHIFT_BITWIDTH = $clog2(RQST_BITWIDTH),
  parameter int PAGE_WIDTH          = 2*L1PA_SHIFT_BITWIDTH+1
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic [REGFILE_ADDR_WIDTH-1:0]  regFile_raddr_i,
  output logic [L1PA_SHIFT_BITWIDTH-1:0] l1pa_shift_fb_o,
  output logic [L1PA_SHIFT_BITWIDTH-1:0] shiftDelta_fb_o,
  output logic                           isGtr_fb_o,
  output logic                           rd_oor_o,
  input  logic                           cfg_wr_valid_i,
  output logic                           cfg_wr_ready_o,
  input  logic [REGFILE_ADDR_WIDTH-1:0]  cfg_wr_addr_i,
  input  logic [PAGE_WIDTH-1:0]          cfg_wr_data_i,
  output logic                           cfg_wr_err_o,
  output logic                           init_done_o,
  output logic                           par_err_o
);

  localparam int AW = REGFILE_ADDR_WIDTH;
  localparam int PW = PAGE_WIDTH;
  localparam int SB = L1PA_SHIFT_BITWIDTH;
`ifdef MEMSHARE_REGFILE_PARITY_EN
  localparam int SW = PW + 1;
`else
  localparam int SW = PW;
`endif
  localparam logic [AW-1:0] LAST = AW'(REGFILE_PAGE_NUM - 1);

  typedef enum logic {CLR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [SW-1:0] mem [REGFILE_PAGE_NUM];

  logic          wr_fire;
  logic          wr_in;
  logic          rd_in;
  logic          hit;
  logic          we;
  logic [AW-1:0] waddr;
  logic [SW-1:0] cfg_word;
  logic [SW-1:0] wword;
  logic [SW-1:0] rword;
  logic [PW-1:0] rdata;
  logic          par_bad;

  assign cfg_wr_ready_o = init_done_o;
  assign wr_fire = cfg_wr_valid_i & cfg_wr_ready_o;
  assign wr_in   = cfg_wr_addr_i <= LAST;
  assign rd_in   = regFile_raddr_i <= LAST;
  assign hit     = wr_fire & wr_in &
                   (cfg_wr_addr_i == regFile_raddr_i);

`ifdef MEMSHARE_REGFILE_PARITY_EN
  assign cfg_word = {^cfg_wr_data_i, cfg_wr_data_i};
  assign par_bad  = rword[PW] ^ (^rword[PW-1:0]);
`else
  assign cfg_word = cfg_wr_data_i;
  assign par_bad  = 1'b0;
`endif

  always_comb begin
    we    = 1'b0;
    waddr = cfg_wr_addr_i;
    wword = cfg_word;
    if (rstn) begin
      if (state == CLR) begin
        we    = 1'b1;
        waddr = clr_cnt;
        wword = '0;
      end else begin
        we = wr_fire & wr_in;
      end
    end
  end

  // write-first: a same-edge write to the read page bypasses the array
  always_comb begin
    rword = '0;
    if (hit)
      rword = cfg_word;
    else if (rd_in)
      rword = mem[regFile_raddr_i];
  end

  assign rdata = rword[PW-1:0];

  always_ff @(posedge sys_clk) begin
    if (we)
      mem[waddr] <= wword;
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state           <= CLR;
      clr_cnt         <= '0;
      init_done_o     <= 1'b0;
      l1pa_shift_fb_o <= '0;
      shiftDelta_fb_o <= '0;
      isGtr_fb_o      <= 1'b0;
      rd_oor_o        <= 1'b0;
      cfg_wr_err_o    <= 1'b0;
      par_err_o       <= 1'b0;
    end else begin
      unique case (state)
        CLR: begin
          clr_cnt         <= clr_cnt + 1'b1;
          l1pa_shift_fb_o <= '0;
          shiftDelta_fb_o <= '0;
          isGtr_fb_o      <= 1'b0;
          rd_oor_o        <= 1'b0;
          cfg_wr_err_o    <= 1'b0;
          par_err_o       <= 1'b0;
          if (clr_cnt == LAST) begin
            state       <= RUN;
            init_done_o <= 1'b1;
          end
        end
        RUN: begin
          l1pa_shift_fb_o <= rd_in ? rdata[PW-1 -: SB] : '0;
          shiftDelta_fb_o <= rd_in ? rdata[SB:1] : '0;
          isGtr_fb_o      <= rd_in & rdata[0];
          rd_oor_o        <= ~rd_in;
          cfg_wr_err_o    <= wr_fire & ~wr_in;
          par_err_o       <= rd_in & par_bad;
        end
        default: state <= CLR;
      endcase
    end
  end

endmodule
